adder_multicycle: RTL and testbench

ADDER_MULTICYCLE -- requirements
Module: adder_multicycle

---
 rtl/adder_pkg.sv | 13 +
 rtl/adder_slice.sv | 29 ++
 rtl/adder_multicycle.sv | 112 +++++++++++
 tb/tb_adder_multicycle.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the multicycle adder: FSM encoding and default geometry.
package adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit ripple-carry adder; also reports the carry into its MSB
// so the caller can derive signed overflow from the top slice.
module adder_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] w_c;

    always_comb begin
        w_c    = '0;
        sum    = '0;
        w_c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]   = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = w_c[CHUNK];
    assign cmsb = w_c[CHUNK-1];

endmodule

// File: rtl/adder_multicycle.sv
// Multicycle adder/subtractor: one CHUNK-bit slice per cycle through a shared
// ripple slice, with a valid/ready handshake on both sides.
module adder_multicycle
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output state_t           dbg_state
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if ((WIDTH % CHUNK) != 0) begin : g_bad_geometry
        $error("adder_multicycle: WIDTH must be a multiple of CHUNK");
    end

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high. in_ready is high in IDLE, and in DONE only while the result is
    // being taken, so a new operand set can be accepted with no bubble.
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_sum;
    logic [IDXW-1:0]  r_idx;
    logic             r_carry, r_cout, r_ovf, r_out_valid;
    logic             w_take, w_accept, w_last;
    logic [CHUNK-1:0] w_slice_sum;
    logic             w_slice_cout, w_slice_cmsb;

    assign w_take   = (r_state == S_DONE) && r_out_valid && out_ready;
    assign in_ready = (r_state == S_IDLE) || w_take;
    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_idx == IDXW'(NCHUNK - 1));

    // Operands shift right each RUN cycle so the slice always sits in the low bits.
    adder_slice #(.CHUNK(CHUNK)) u_slice (
        .a    (r_a[CHUNK-1:0]),
        .b    (r_b[CHUNK-1:0]),
        .cin  (r_carry),
        .sum  (w_slice_sum),
        .cout (w_slice_cout),
        .cmsb (w_slice_cmsb)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  if (w_take) w_next = in_valid ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a     <= A;
                r_b     <= Sub ? ~B : B;
                r_carry <= Sub | Cin;
                r_idx   <= '0;
            end else if (r_state == S_RUN) begin
                r_a     <= r_a >> CHUNK;
                r_b     <= r_b >> CHUNK;
                r_sum   <= (r_sum >> CHUNK) | (WIDTH'(w_slice_sum) << (WIDTH - CHUNK));
                r_carry <= w_slice_cout;
                r_idx   <= r_idx + IDXW'(1);
                if (w_last) begin
                    r_cout <= w_slice_cout;
                    r_ovf  <= w_slice_cout ^ w_slice_cmsb;
                end
            end
            // Result becomes visible one edge after DONE is entered.
            if (w_take) begin
                r_out_valid <= 1'b0;
            end else if (r_state == S_DONE) begin
                r_out_valid <= 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign Sum       = r_sum;
    assign Cout      = r_cout;
    assign Ovf       = r_ovf;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_adder_multicycle.sv
// Bench for adder_multicycle: four geometries checked every cycle against an
// arithmetic model with a result queue, plus directed corner cases on 32/8.
module tb_adder_multicycle;
    import adder_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [63:0] a_s[4], b_s[4], sum_s[4];
    logic        iv[4], ordy[4], cin_s[4], sub_s[4];
    logic        irdy_s[4], ov_s[4], co_s[4], of_s[4];
    logic [1:0]  st_s[4];

    int n_checks = 0;
    int n_fail   = 0;
    int n_ops[4] = '{0, 0, 0, 0};
    bit chk_en   = 1'b0;

    task automatic check(input string nm, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Returns {ovf, cout, sum} for a w-bit add (a+b+cin) or subtract (a-b).
    function automatic logic [65:0] golden(input int w, input logic [63:0] a, input logic [63:0] b,
                                           input logic cin, input logic sub);
        logic [63:0] m, bm, s;
        logic [64:0] full;
        logic        c, sa, sb, ss, ov;
        m    = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        bm   = sub ? (~b & m) : (b & m);
        c    = sub ? 1'b1 : cin;
        full = {1'b0, a & m} + {1'b0, bm} + {64'd0, c};
        s    = full[63:0] & m;
        sa   = a[w-1];
        sb   = b[w-1];
        ss   = s[w-1];
        ov   = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
        return {ov, full[w], s};
    endfunction

    function automatic logic [63:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return '1;
            1:       return '0;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int W  = (g == 2) ? 16 : (g == 3) ? 64 : 32;
        localparam int C  = (g == 0) ? 8 : (g == 1) ? 32 : (g == 2) ? 4 : 16;
        localparam int NC = W / C;

        logic [W-1:0] w_sum;
        state_t       w_st;
        logic         m_valid = 1'b0;
        int           m_wait  = 0;
        logic         m_acc;
        logic [65:0]  exp_q[$];

        adder_multicycle #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv[g]),
            .in_ready  (irdy_s[g]),
            .A         (a_s[g][W-1:0]),
            .B         (b_s[g][W-1:0]),
            .Cin       (cin_s[g]),
            .Sub       (sub_s[g]),
            .out_valid (ov_s[g]),
            .out_ready (ordy[g]),
            .Sum       (w_sum),
            .Cout      (co_s[g]),
            .Ovf       (of_s[g]),
            .dbg_state (w_st)
        );

        assign sum_s[g] = 64'(w_sum);
        assign st_s[g]  = w_st;

        // Model: a result appears NC+1 edges after acceptance and stays until taken.
        always @(posedge clk) begin
            if (rst) begin
                m_valid = 1'b0;
                m_wait  = 0;
                exp_q.delete();
            end else begin
                m_acc = iv[g] && ((!m_valid && m_wait == 0) || (m_valid && ordy[g]));
                if (m_valid && ordy[g]) begin
                    m_valid = 1'b0;
                    void'(exp_q.pop_front());
                    n_ops[g]++;
                end
                if (m_wait > 0) begin
                    m_wait--;
                    if (m_wait == 0) m_valid = 1'b1;
                end
                if (m_acc) begin
                    exp_q.push_back(golden(W, a_s[g], b_s[g], cin_s[g], sub_s[g]));
                    m_wait = NC + 1;
                end
            end
        end

        always @(negedge clk) begin
            if (chk_en) begin
                check($sformatf("in_ready_cfg%0d", g), 66'(irdy_s[g]),
                      66'((!m_valid && m_wait == 0) || (m_valid && ordy[g])));
                check($sformatf("out_valid_cfg%0d", g), 66'(ov_s[g]), 66'(m_valid));
                if (m_valid) begin
                    check($sformatf("sum_cfg%0d", g), 66'(sum_s[g]), 66'(exp_q[0][63:0]));
                    check($sformatf("cout_cfg%0d", g), 66'(co_s[g]), 66'(exp_q[0][64]));
                    check($sformatf("ovf_cfg%0d", g), 66'(of_s[g]), 66'(exp_q[0][65]));
                end
            end
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub,
                          input logic [31:0] es, input logic ec, input logic eo, input string nm);
        int lat;
        a_s[0]   = 64'(a);
        b_s[0]   = 64'(b);
        cin_s[0] = cin;
        sub_s[0] = sub;
        iv[0]    = 1'b1;
        ordy[0]  = 1'b1;
        @(posedge clk); #1;
        iv[0]    = 1'b0;
        a_s[0]   = {$urandom, $urandom};
        b_s[0]   = {$urandom, $urandom};
        cin_s[0] = ~cin;
        sub_s[0] = ~sub;
        lat = 0;
        while (!ov_s[0] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, "_latency"}, 66'(lat), 66'd5);
        check({nm, "_sum"}, 66'(sum_s[0]), 66'(es));
        check({nm, "_cout"}, 66'(co_s[0]), 66'(ec));
        check({nm, "_ovf"}, 66'(of_s[0]), 66'(eo));
        @(posedge clk); #1;
    endtask

    initial begin
        int  lat;
        int  cyc;
        bit  done_all;
        rst = 1'b1;
        for (int g = 0; g < 4; g++) begin
            iv[g] = 1'b0; ordy[g] = 1'b1; a_s[g] = '0; b_s[g] = '0;
            cin_s[g] = 1'b0; sub_s[g] = 1'b0;
        end

        check("model_add", golden(32, 64'd50, 64'd10, 1'b1, 1'b0), {2'b00, 64'd61});
        check("model_ovf", golden(32, 64'h7FFF_FFFF, 64'd1, 1'b0, 1'b0), {2'b10, 64'h8000_0000});
        check("model_borrow", golden(32, 64'd0, 64'd1, 1'b0, 1'b1), {2'b00, 64'hFFFF_FFFF});
        check("model_sub16_ovf", golden(16, 64'h8000, 64'd1, 1'b0, 1'b1), {2'b11, 64'h7FFF});
        check("model_wrap64", golden(64, '1, 64'd1, 1'b0, 1'b0), {2'b01, 64'd0});

        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 66'(st_s[0]), 66'(S_IDLE));
        check("rst_out_valid", 66'(ov_s[0]), 66'd0);
        check("rst_sum", 66'(sum_s[0]), 66'd0);
        check("rst_cout", 66'(co_s[0]), 66'd0);
        check("rst_ovf", 66'(of_s[0]), 66'd0);
        check("rst_in_ready", 66'(irdy_s[0]), 66'd1);
        rst    = 1'b0;
        chk_en = 1'b1;

        run_op(32'd50, 32'd10, 1'b1, 1'b0, 32'd61, 1'b0, 1'b0, "add");
        run_op(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, "wrap");
        run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "ovf");
        run_op(32'd100, 32'd50, 1'b1, 1'b1, 32'd50, 1'b1, 1'b0, "sub");
        run_op(32'd0, 32'd1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, "borrow");

        // Backpressure: result must hold while stalled, then a back-to-back accept.
        a_s[0] = 64'd5; b_s[0] = 64'd7; cin_s[0] = 1'b0; sub_s[0] = 1'b0;
        iv[0] = 1'b1; ordy[0] = 1'b0;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        lat = 0;
        while (!ov_s[0] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_latency", 66'(lat), 66'd5);
        for (int i = 0; i < 5; i++) begin
            a_s[0] = {$urandom, $urandom};
            b_s[0] = {$urandom, $urandom};
            iv[0]  = (i % 2 == 0);
            @(posedge clk); #1;
            check("bp_hold_valid", 66'(ov_s[0]), 66'd1);
            check("bp_hold_sum", 66'(sum_s[0]), 66'd12);
            check("bp_hold_in_ready", 66'(irdy_s[0]), 66'd0);
        end
        a_s[0] = 64'd1000; b_s[0] = 64'd24; cin_s[0] = 1'b0; sub_s[0] = 1'b0;
        iv[0] = 1'b1; ordy[0] = 1'b1;
        #1;
        check("b2b_in_ready", 66'(irdy_s[0]), 66'd1);
        @(posedge clk); #1;
        iv[0] = 1'b0;
        check("b2b_valid_drop", 66'(ov_s[0]), 66'd0);
        lat = 0;
        while (!ov_s[0] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_latency", 66'(lat), 66'd5);
        check("b2b_sum", 66'(sum_s[0]), 66'd1024);
        @(posedge clk); #1;

        // Reset while the third slice is being added.
        a_s[0] = 64'd3; b_s[0] = 64'd4; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("pre_rst_state", 66'(st_s[0]), 66'(S_RUN));
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_state", 66'(st_s[0]), 66'(S_IDLE));
        check("midrst_out_valid", 66'(ov_s[0]), 66'd0);
        check("midrst_sum", 66'(sum_s[0]), 66'd0);
        rst = 1'b0;
        run_op(32'd9, 32'd8, 1'b0, 1'b0, 32'd17, 1'b0, 1'b0, "after_rst");

        // Random operations with stalls on every geometry.
        cyc = 0;
        done_all = 1'b0;
        while (!done_all && cyc < 40000) begin
            @(posedge clk); #2;
            for (int g = 0; g < 4; g++) begin
                iv[g]    = ($urandom_range(0, 3) != 0);
                ordy[g]  = ($urandom_range(0, 3) != 0);
                a_s[g]   = rnd_operand();
                b_s[g]   = rnd_operand();
                cin_s[g] = 1'($urandom_range(0, 1));
                sub_s[g] = 1'($urandom_range(0, 1));
            end
            cyc++;
            done_all = 1'b1;
            for (int g = 0; g < 4; g++) begin
                if (n_ops[g] < 250) done_all = 1'b0;
            end
        end
        check("random_ops_completed", 66'(done_all), 66'd1);
        for (int g = 0; g < 4; g++) begin
            iv[g] = 1'b0;
            ordy[g] = 1'b1;
        end
        repeat (20) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
